// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

   typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_t;

   // Address width that never collapses to zero bits for tiny depths.
   function automatic int rf_aw(input int depth);
      return (depth > 2) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/regfile_write_arbiter.sv
// Per-entry write select over NW ports; the highest-numbered enabled port wins.
module regfile_write_arbiter
   import regfile_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 8,
   parameter int NW    = 2,
   parameter int AW    = 3
) (
   input  logic                          en,
   input  logic [NW-1:0]                 we,
   input  logic [NW*AW-1:0]              waddr,
   input  logic [NW*WIDTH-1:0]           wdata,
   output logic [DEPTH-1:0]              ent_we,
   output logic [DEPTH-1:0][WIDTH-1:0]   ent_wdata
);

   // Ascending port scan: a later match overrides an earlier one.
   always_comb begin
      ent_we    = '0;
      ent_wdata = '0;
      for (int e = 0; e < DEPTH; e++) begin
         for (int p = 0; p < NW; p++) begin
            if (en && we[p] && (waddr[p*AW +: AW] == AW'(e))) begin
               ent_we[e]    = 1'b1;
               ent_wdata[e] = wdata[p*WIDTH +: WIDTH];
            end
         end
      end
   end

endmodule

// File: rtl/regfile_multiport.sv
// Multi-port register file with async reads, sync writes, optional bypass,
// optional hardwired-zero entry 0 and a one-entry-per-cycle clear sweep.
module regfile_multiport
   import regfile_pkg::*;
#(
   parameter  int WIDTH     = 4,
   parameter  int DEPTH     = 8,
   parameter  int NR        = 2,
   parameter  int NW        = 2,
   parameter  int BYPASS    = 1,
   parameter  int ZERO_REG0 = 0,
   localparam int AW        = rf_aw(DEPTH)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 clear_req,
   output logic                 clear_busy,
   input  logic [NW-1:0]        we,
   input  logic [NW*AW-1:0]     waddr,
   input  logic [NW*WIDTH-1:0]  wdata,
   input  logic [NR*AW-1:0]     raddr,
   output logic [NR*WIDTH-1:0]  rdata,
   output rf_state_t            dbg_state
);

   rf_state_t                     state;
   logic [AW-1:0]                 cnt;
   logic [WIDTH-1:0]              mem [DEPTH];
   logic [DEPTH-1:0]              arb_we;
   logic [DEPTH-1:0]              wr_en;
   logic [DEPTH-1:0][WIDTH-1:0]   arb_wdata;
   logic                          wr_allow;

   assign wr_allow = (state == RF_IDLE);

   regfile_write_arbiter #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .NW    (NW),
      .AW    (AW)
   ) u_arb (
      .en        (wr_allow),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .ent_we    (arb_we),
      .ent_wdata (arb_wdata)
   );

   // The same masked enables drive both storage and bypass, so entry 0 never forwards.
   always_comb begin
      wr_en = arb_we;
      if (ZERO_REG0 != 0) wr_en[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= RF_IDLE;
         cnt   <= '0;
         for (int e = 0; e < DEPTH; e++) mem[e] <= '0;
      end else begin
         case (state)
            RF_IDLE: begin
               for (int e = 0; e < DEPTH; e++) begin
                  if (wr_en[e]) mem[e] <= arb_wdata[e];
               end
               if (clear_req) begin
                  state <= RF_CLEAR;
                  cnt   <= '0;
               end
            end
            RF_CLEAR: begin
               mem[cnt] <= '0;
               cnt      <= cnt + 1'b1;
               // cnt wraps back to 0 on the final increment.
               if (cnt == AW'(DEPTH - 1)) state <= RF_IDLE;
            end
         endcase
      end
   end

   assign clear_busy = (state == RF_CLEAR);
   assign dbg_state  = state;

   always_comb begin
      rdata = '0;
      for (int r = 0; r < NR; r++) begin
         rdata[r*WIDTH +: WIDTH] = mem[raddr[r*AW +: AW]];
         if ((BYPASS != 0) && wr_en[raddr[r*AW +: AW]])
            rdata[r*WIDTH +: WIDTH] = arb_wdata[raddr[r*AW +: AW]];
         if ((ZERO_REG0 != 0) && (raddr[r*AW +: AW] == '0))
            rdata[r*WIDTH +: WIDTH] = '0;
      end
   end

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: bypass and non-bypass instances share stimulus,
// plus a hardwired-zero 16-entry, 3-read-port instance.
module tb_regfile_multiport;
   import regfile_pkg::*;

   localparam int W   = 4;
   localparam int D   = 8;
   localparam int AW  = 3;
   localparam int NR  = 2;
   localparam int NW  = 2;
   localparam int D2  = 16;
   localparam int AW2 = 4;
   localparam int NR2 = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   // Shared stimulus for the BYPASS=1 and BYPASS=0 instances
   logic              clear_req;
   logic [NW-1:0]     we;
   logic [NW*AW-1:0]  waddr;
   logic [NW*W-1:0]   wdata;
   logic [NR*AW-1:0]  raddr;
   logic [NR*W-1:0]   rdata_b, rdata_n;
   logic              busy_b, busy_n;
   rf_state_t         st_b, st_n;

   logic              z_clear_req;
   logic [NW-1:0]     z_we;
   logic [NW*AW2-1:0] z_waddr;
   logic [NW*W-1:0]   z_wdata;
   logic [NR2*AW2-1:0] z_raddr;
   logic [NR2*W-1:0]  z_rdata;
   logic              z_busy;
   rf_state_t         z_st;

   regfile_multiport #(.WIDTH(W), .DEPTH(D), .NR(NR), .NW(NW), .BYPASS(1), .ZERO_REG0(0)) dut_b (
      .clk(clk), .reset_n(reset_n), .clear_req(clear_req), .clear_busy(busy_b),
      .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata_b), .dbg_state(st_b));

   regfile_multiport #(.WIDTH(W), .DEPTH(D), .NR(NR), .NW(NW), .BYPASS(0), .ZERO_REG0(0)) dut_n (
      .clk(clk), .reset_n(reset_n), .clear_req(clear_req), .clear_busy(busy_n),
      .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata_n), .dbg_state(st_n));

   regfile_multiport #(.WIDTH(W), .DEPTH(D2), .NR(NR2), .NW(NW), .BYPASS(1), .ZERO_REG0(1)) dut_z (
      .clk(clk), .reset_n(reset_n), .clear_req(z_clear_req), .clear_busy(z_busy),
      .we(z_we), .waddr(z_waddr), .wdata(z_wdata), .raddr(z_raddr), .rdata(z_rdata), .dbg_state(z_st));

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Reference model: array contents plus remaining sweep position
   logic [W-1:0] m_mem [D];
   bit           m_busy;
   int           m_idx;
   logic [W-1:0] zm [D2];

   task automatic m_reset();
      for (int i = 0; i < D; i++) m_mem[i] = '0;
      m_busy = 1'b0;
      m_idx  = 0;
   endtask

   function automatic logic [W-1:0] m_read(input int a, input bit byp);
      logic [W-1:0] v;
      v = m_mem[a];
      if (byp && !m_busy)
         for (int p = 0; p < NW; p++)
            if (we[p] && int'(waddr[p*AW +: AW]) == a) v = wdata[p*W +: W];
      return v;
   endfunction

   function automatic logic [W-1:0] z_read(input int a);
      logic [W-1:0] v;
      v = zm[a];
      for (int p = 0; p < NW; p++)
         if (z_we[p] && int'(z_waddr[p*AW2 +: AW2]) == a) v = z_wdata[p*W +: W];
      if (a == 0) v = '0;
      return v;
   endfunction

   function automatic logic [W-1:0] rd_b(input int r);
      return rdata_b[r*W +: W];
   endfunction

   function automatic logic [W-1:0] rd_n(input int r);
      return rdata_n[r*W +: W];
   endfunction

   function automatic logic [W-1:0] rd_z(input int r);
      return z_rdata[r*W +: W];
   endfunction

   // ---------------- driver tasks ----------------
   task automatic set_w(input int p, input bit en, input int a, input int d);
      we[p]              = en;
      waddr[p*AW +: AW]  = AW'(a);
      wdata[p*W +: W]    = W'(d);
   endtask

   task automatic set_r(input int r, input int a);
      raddr[r*AW +: AW] = AW'(a);
   endtask

   task automatic set_zw(input int p, input bit en, input int a, input int d);
      z_we[p]               = en;
      z_waddr[p*AW2 +: AW2] = AW2'(a);
      z_wdata[p*W +: W]     = W'(d);
   endtask

   task automatic set_zr(input int r, input int a);
      z_raddr[r*AW2 +: AW2] = AW2'(a);
   endtask

   // Mid-cycle comparison of both instances against the model
   task automatic pre();
      #2;
      chk("busy_byp", busy_b, m_busy);
      chk("busy_nobyp", busy_n, m_busy);
      for (int r = 0; r < NR; r++) begin
         int a;
         a = int'(raddr[r*AW +: AW]);
         chk($sformatf("rd_byp%0d_a%0d", r, a), rd_b(r), m_read(a, 1'b1));
         chk($sformatf("rd_nobyp%0d_a%0d", r, a), rd_n(r), m_read(a, 1'b0));
      end
   endtask

   task automatic post();
      @(posedge clk);
      if (!m_busy) begin
         for (int p = 0; p < NW; p++)
            if (we[p]) m_mem[int'(waddr[p*AW +: AW])] = wdata[p*W +: W];
         if (clear_req) begin
            m_busy = 1'b1;
            m_idx  = 0;
         end
      end else begin
         m_mem[m_idx] = '0;
         m_idx++;
         if (m_idx == D) m_busy = 1'b0;
      end
      #1;
   endtask

   task automatic step();
      pre();
      post();
   endtask

   task automatic z_pre();
      #2;
      chk("z_busy", z_busy, 1'b0);
      for (int r = 0; r < NR2; r++) begin
         int a;
         a = int'(z_raddr[r*AW2 +: AW2]);
         chk($sformatf("z_rd%0d_a%0d", r, a), rd_z(r), z_read(a));
      end
   endtask

   task automatic z_post();
      @(posedge clk);
      for (int p = 0; p < NW; p++)
         if (z_we[p] && z_waddr[p*AW2 +: AW2] != '0)
            zm[int'(z_waddr[p*AW2 +: AW2])] = z_wdata[p*W +: W];
      #1;
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int busy_cnt;
      reset_n = 1'b0;
      clear_req = 1'b0; we = '0; waddr = '0; wdata = '0; raddr = '0;
      z_clear_req = 1'b0; z_we = '0; z_waddr = '0; z_wdata = '0; z_raddr = '0;
      m_reset();
      for (int i = 0; i < D2; i++) zm[i] = '0;

      #3;
      chk("rst_rd0", rd_b(0), 4'h0);
      chk("rst_busy", busy_b, 1'b0);
      #9;
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Reset value after a write
      set_w(0, 1'b1, 3, 4'hA);
      step();
      we = '0;
      set_r(0, 3); set_r(1, 3);
      pre();
      chk("t1_written", rd_b(0), 4'hA);
      reset_n = 1'b0;
      #1;
      chk("t1_rst_rd_byp", rd_b(0), 4'h0);
      chk("t1_rst_rd_nobyp", rd_n(1), 4'h0);
      chk("t1_rst_busy", busy_b, 1'b0);
      reset_n = 1'b1;
      m_reset();
      #1;
      post();

      // Dual-write conflict and latency
      set_w(0, 1'b1, 5, 4'h3); set_w(1, 1'b1, 5, 4'hC);
      step();
      we = '0;
      set_r(0, 5);
      pre();
      chk("t2_conflict", rd_n(0), 4'hC);
      post();
      set_w(0, 1'b1, 5, 4'h3); set_w(1, 1'b1, 6, 4'hC);
      step();
      we = '0;
      set_r(0, 5); set_r(1, 6);
      pre();
      chk("t2_split_5", rd_n(0), 4'h3);
      chk("t2_split_6", rd_n(1), 4'hC);
      post();

      // Bypass vs stored value
      set_w(0, 1'b1, 2, 4'h5);
      step();
      set_w(0, 1'b1, 2, 4'h9);
      set_r(0, 2);
      pre();
      chk("t3_byp_same", rd_b(0), 4'h9);
      chk("t3_nobyp_old", rd_n(0), 4'h5);
      post();
      we = '0;
      pre();
      chk("t3_nobyp_next", rd_n(0), 4'h9);
      post();

      // Clear sweep with writes and a second request during it
      for (int i = 0; i < D / 2; i++) begin
         set_w(0, 1'b1, 2 * i, 4'hF);
         set_w(1, 1'b1, 2 * i + 1, 4'hF);
         step();
      end
      we = '0;
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      busy_cnt = 0;
      for (int c = 0; c < 12; c++) begin
         if (c < D) begin
            we = NW'($urandom_range(1, 3));
            for (int p = 0; p < NW; p++) begin
               waddr[p*AW +: AW] = AW'($urandom_range(0, D - 1));
               wdata[p*W +: W]   = W'($urandom_range(0, 14));
            end
            clear_req = (c == 4);
            set_r(0, (c == 0) ? 0 : c - 1);
            set_r(1, c);
         end else begin
            we = '0;
            clear_req = 1'b0;
         end
         pre();
         if (busy_b) busy_cnt++;
         if (c >= 1 && c < D) chk($sformatf("t4_cleared_%0d", c - 1), rd_b(0), 4'h0);
         if (c < D) chk($sformatf("t4_pending_%0d", c), rd_b(1), 4'hF);
         post();
      end
      chk("t4_busy_len", busy_cnt, D);
      for (int a = 0; a < D; a += 2) begin
         set_r(0, a); set_r(1, a + 1);
         pre();
         chk($sformatf("t4_after_%0d", a), rd_b(0), 4'h0);
         chk($sformatf("t4_after_%0d", a + 1), rd_n(1), 4'h0);
         post();
      end

      // Reset during sweep
      set_w(0, 1'b1, 1, 4'h7); set_w(1, 1'b1, 6, 4'hB);
      step();
      we = '0;
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      repeat (3) step();
      #2;
      chk("t5_busy_before", busy_b, 1'b1);
      reset_n = 1'b0;
      #1;
      chk("t5_busy_byp", busy_b, 1'b0);
      chk("t5_busy_nobyp", busy_n, 1'b0);
      for (int a = 0; a < D; a++) begin
         set_r(0, a); set_r(1, D - 1 - a);
         #1;
         chk($sformatf("t5_zero_%0d", a), rd_b(0), 4'h0);
         chk($sformatf("t5_zero_n_%0d", D - 1 - a), rd_n(1), 4'h0);
      end
      m_reset();
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      set_w(0, 1'b1, 4, 4'h6);
      step();
      we = '0;
      set_r(0, 4);
      pre();
      chk("t5_write_after", rd_n(0), 4'h6);
      post();

      // Randomized traffic against the model
      repeat (300) begin
         we = NW'($urandom_range(0, 3));
         for (int p = 0; p < NW; p++) begin
            waddr[p*AW +: AW] = AW'($urandom_range(0, D - 1));
            wdata[p*W +: W]   = W'($urandom_range(0, 15));
         end
         for (int r = 0; r < NR; r++) set_r(r, $urandom_range(0, D - 1));
         clear_req = ($urandom_range(0, 39) == 0);
         step();
      end
      we = '0;
      clear_req = 1'b0;
      repeat (10) step();

      // Hardwired-zero instance
      set_zw(0, 1'b1, 0, 4'h7); set_zw(1, 1'b1, 9, 4'h5);
      set_zr(0, 0); set_zr(1, 0); set_zr(2, 9);
      z_pre();
      chk("t6_same_p0", rd_z(0), 4'h0);
      chk("t6_same_p1", rd_z(1), 4'h0);
      chk("t6_same_byp9", rd_z(2), 4'h5);
      z_post();
      z_we = '0;
      set_zr(2, 0);
      z_pre();
      chk("t6_next_p0", rd_z(0), 4'h0);
      chk("t6_next_p2", rd_z(2), 4'h0);
      z_post();
      repeat (150) begin
         z_we = NW'($urandom_range(0, 3));
         for (int p = 0; p < NW; p++) begin
            z_waddr[p*AW2 +: AW2] = AW2'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, D2 - 1));
            z_wdata[p*W +: W]     = W'($urandom_range(1, 15));
         end
         for (int r = 0; r < NR2; r++) set_zr(r, $urandom_range(0, D2 - 1));
         z_pre();
         z_post();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
